vram_access_arbiter: RTL and testbench

// Shares one single-port, synchronous-read text-mode video RAM (character map) between the

---
 rtl/vram_access_arbiter.sv | 131 +++++++++++++
 tb/tb_vram_access_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_access_arbiter.sv
// Arbitrates a single-port text-mode character RAM between the display fetch path
// (always wins) and one handshaked writer that uses the leftover cycles.
module vram_access_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int CHAR_W_LOG2  = 3,
  parameter int CHAR_H_LOG2  = 4,
  parameter int WR_ACTIVE_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [31:0] COLS_U  = 32'(COLS);
  localparam logic [31:0] CELLS_U = 32'(COLS * ROWS);

  logic [1:0]        state_reg, state_next;
  logic              err_reg, err_next;
  logic              rd_valid_reg;
  logic [DATA_W-1:0] rd_hold_reg;

  logic              display_slot;
  logic              free_slot;
  logic              grant;
  logic              addr_in_range;
  logic              do_write;
  logic [9:0]        char_col;
  logic [9:0]        char_row;
  logic [31:0]       disp_lin;
  logic [ADDR_W-1:0] disp_addr;

  assign display_slot = p_tick & video_on;
  assign free_slot    = ~display_slot & ((WR_ACTIVE_EN != 0) | ~video_on);

  assign char_col  = pix_x >> CHAR_W_LOG2;
  assign char_row  = pix_y >> CHAR_H_LOG2;
  assign disp_lin  = {22'd0, char_row} * COLS_U + {22'd0, char_col};
  assign disp_addr = disp_lin[ADDR_W-1:0];

  assign addr_in_range = {{(32-ADDR_W){1'b0}}, wr_addr} < CELLS_U;

  // A grant consumes the request even when the address is bad, so the error
  // response follows the same ACK/DROP path as a real write.
  assign grant    = ~reset & wr_req & free_slot & (state_reg == ST_IDLE);
  assign do_write = grant & addr_in_range;

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant) begin
          state_next = ST_ACK;
          err_next   = ~addr_in_range;
        end
      end
      ST_ACK: begin
        state_next = ST_DROP;
      end
      ST_DROP: begin
        if (!wr_req) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        err_next   = 1'b0;
      end
    endcase
  end

  // RAM port is a pure function of this cycle's slot decision.
  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (!reset) begin
      if (do_write) begin
        ram_addr = wr_addr;
        ram_we   = 1'b1;
        ram_din  = wr_data;
      end else if (video_on) begin
        ram_addr = disp_addr;
      end
    end
  end

  assign wr_ack = ~reset & (state_reg == ST_ACK) & ~err_reg;
  assign wr_err = ~reset & (state_reg == ST_ACK) & err_reg;

  // RAM read data arrives one clk after the address, so it is passed straight
  // through in that cycle and captured to hold the value afterwards.
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_valid_reg ? ram_dout : rd_hold_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      err_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_hold_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      err_reg      <= err_next;
      rd_valid_reg <= display_slot;
      rd_hold_reg  <= rd_data;
    end
  end

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Bench for vram_access_arbiter: behavioural character RAM, fetch scoreboard,
// address vector table and hand-written handshake sequences.
module tb_vram_access_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic        wr_req = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  ram_dout = '0;

  logic        wr_ack, wr_err, ram_we, rd_valid;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din, rd_data;

  logic        wr_ack_b, wr_err_b, ram_we_b, rd_valid_b;
  logic [11:0] ram_addr_b;
  logic [7:0]  ram_din_b, rd_data_b;

  always #5 clk = ~clk;

  vram_access_arbiter dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pix_x(pix_x), .pix_y(pix_y), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  // Blanking-only writer variant; shares inputs, only its RAM strobe is checked.
  vram_access_arbiter #(.WR_ACTIVE_EN(0)) dut_blank (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pix_x(pix_x), .pix_y(pix_y), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack_b), .wr_err(wr_err_b), .ram_addr(ram_addr_b),
    .ram_we(ram_we_b), .ram_din(ram_din_b), .ram_dout(ram_dout),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  logic       preload = 1'b1;
  logic [7:0] mem [0:4095];
  logic [7:0] exp_mem [0:4095];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  int we_count = 0;
  int ack_count = 0;
  always @(posedge clk) begin
    if (ram_we) we_count <= we_count + 1;
    if (wr_ack) ack_count <= ack_count + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic       fetch_d = 1'b0;
  logic       rst_d = 1'b0;
  logic [7:0] last_exp = 8'h00;

  typedef struct {
    logic        vo;
    logic        pt;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [11:0] addr;
    logic        fetch;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Records what the DUT must do after the coming edge, then crosses it.
  task automatic cycle_start();
    fetch_d = video_on & p_tick & ~reset;
    rst_d   = reset;
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle sample point: the fetch scoreboard runs before per-test checks.
  task automatic mid();
    @(negedge clk);
    if (rst_d) last_exp = 8'h00;
    chk("rd_valid", 32'(rd_valid), 32'(fetch_d));
    if (fetch_d) begin
      if (exp_q.size() == 0) chk("rd_queue_nonempty", 32'(exp_q.size()), 32'd1);
      else last_exp = exp_q.pop_front();
    end
    chk("rd_data", 32'(rd_data), 32'(last_exp));
    $display("cycle t=%0t addr=%0d we=%0b din=%02h ack=%0b err=%0b rdv=%0b rd=%02h",
             $time, ram_addr, ram_we, ram_din, wr_ack, wr_err, rd_valid, rd_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) exp_mem[i] = pat(i);
    vecs[0]  = '{1'b1, 1'b1, 10'd16,  10'd32,  12'd162,  1'b1};
    vecs[1]  = '{1'b1, 1'b1, 10'd0,   10'd0,   12'd0,    1'b1};
    vecs[2]  = '{1'b1, 1'b1, 10'd639, 10'd479, 12'd2399, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 10'd8,   10'd16,  12'd81,   1'b1};
    vecs[4]  = '{1'b1, 1'b1, 10'd100, 10'd200, 12'd972,  1'b1};
    vecs[5]  = '{1'b1, 1'b0, 10'd100, 10'd200, 12'd972,  1'b0};
    vecs[6]  = '{1'b0, 1'b0, 10'd700, 10'd500, 12'd0,    1'b0};
    vecs[7]  = '{1'b1, 1'b1, 10'd40,  10'd0,   12'd5,    1'b1};
    vecs[8]  = '{1'b1, 1'b1, 10'd80,  10'd0,   12'd10,   1'b1};
    vecs[9]  = '{1'b1, 1'b1, 10'd56,  10'd0,   12'd7,    1'b1};
    vecs[10] = '{1'b1, 1'b1, 10'd64,  10'd0,   12'd8,    1'b1};
    vecs[11] = '{1'b0, 1'b1, 10'd16,  10'd32,  12'd0,    1'b0};

    // Reset held with a pending request: nothing may reach the RAM.
    wr_req = 1'b1; wr_addr = 12'd5; wr_data = 8'h41;
    @(posedge clk); #1;
    preload = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle_start();
      mid();
      chk("reset_ram_we", 32'(ram_we), 32'd0);
      chk("reset_ram_addr", 32'(ram_addr), 32'd0);
      chk("reset_ram_din", 32'(ram_din), 32'd0);
      chk("reset_wr_ack", 32'(wr_ack), 32'd0);
      chk("reset_wr_err", 32'(wr_err), 32'd0);
    end
    chk("reset_we_count", 32'(we_count), 32'd0);
    cycle_start(); reset = 1'b0; wr_req = 1'b0; mid();

    // Blanking write, then a long-held request that must not write again.
    cycle_start(); wr_req = 1'b1; wr_addr = 12'd5; wr_data = 8'h41; mid();
    chk("wr_we", 32'(ram_we), 32'd1);
    chk("wr_addr", 32'(ram_addr), 32'd5);
    chk("wr_din", 32'(ram_din), 32'h41);
    chk("wr_ack_early", 32'(wr_ack), 32'd0);
    exp_mem[5] = 8'h41;
    cycle_start(); mid();
    chk("wr_ack", 32'(wr_ack), 32'd1);
    chk("wr_ack_we", 32'(ram_we), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cycle_start(); mid();
      chk("hold_we", 32'(ram_we), 32'd0);
      chk("hold_ack", 32'(wr_ack), 32'd0);
    end
    chk("hold_we_count", 32'(we_count), 32'd1);
    cycle_start(); wr_req = 1'b0; mid();

    // Out-of-range address reports an error; last valid cell is accepted.
    cycle_start(); wr_req = 1'b1; wr_addr = 12'd2400; wr_data = 8'hEE; mid();
    chk("oor_we", 32'(ram_we), 32'd0);
    chk("oor_err_early", 32'(wr_err), 32'd0);
    cycle_start(); mid();
    chk("oor_err", 32'(wr_err), 32'd1);
    chk("oor_ack", 32'(wr_ack), 32'd0);
    cycle_start(); mid();
    chk("oor_err_once", 32'(wr_err), 32'd0);
    cycle_start(); wr_req = 1'b0; mid();
    cycle_start(); wr_req = 1'b1; wr_addr = 12'd2399; wr_data = 8'hC3; mid();
    chk("edge_we", 32'(ram_we), 32'd1);
    chk("edge_addr", 32'(ram_addr), 32'd2399);
    exp_mem[2399] = 8'hC3;
    cycle_start(); mid();
    chk("edge_ack", 32'(wr_ack), 32'd1);
    chk("edge_err", 32'(wr_err), 32'd0);
    cycle_start(); wr_req = 1'b0; mid();
    cycle_start(); mid();

    // Active video: the write slips into the p_tick=0 gap; blanking-only waits.
    video_on = 1'b1; pix_y = 10'd48;
    cycle_start(); p_tick = 1'b1; pix_x = 10'd0;
    wr_req = 1'b1; wr_addr = 12'd10; wr_data = 8'h77;
    exp_q.push_back(exp_mem[240]); mid();
    chk("act_slot_we", 32'(ram_we), 32'd0);
    chk("act_slot_addr", 32'(ram_addr), 32'd240);
    chk("act_blank_we", 32'(ram_we_b), 32'd0);
    cycle_start(); p_tick = 1'b0; mid();
    chk("act_gap_we", 32'(ram_we), 32'd1);
    chk("act_gap_addr", 32'(ram_addr), 32'd10);
    chk("act_gap_din", 32'(ram_din), 32'h77);
    chk("act_gap_blank_we", 32'(ram_we_b), 32'd0);
    exp_mem[10] = 8'h77;
    for (int k = 0; k < 6; k++) begin
      cycle_start();
      p_tick = (k % 2 == 0);
      pix_x = 10'(k / 2 + 1);
      if (p_tick) exp_q.push_back(exp_mem[240]);
      mid();
      if (k == 0) chk("act_ack", 32'(wr_ack), 32'd1);
      chk("act_we", 32'(ram_we), 32'd0);
      chk("act_blank_wait", 32'(ram_we_b), 32'd0);
      if (p_tick) chk("act_addr", 32'(ram_addr), 32'd240);
    end
    cycle_start(); video_on = 1'b0; p_tick = 1'b0; mid();
    chk("blank_only_we", 32'(ram_we_b), 32'd1);
    chk("blank_only_addr", 32'(ram_addr_b), 32'd10);
    chk("blank_main_we", 32'(ram_we), 32'd0);
    cycle_start(); wr_req = 1'b0; mid();
    cycle_start(); mid();

    // Reset while acknowledging: ack suppressed, next request served at once.
    cycle_start(); wr_req = 1'b1; wr_addr = 12'd7; wr_data = 8'h33; mid();
    chk("rack_we", 32'(ram_we), 32'd1);
    exp_mem[7] = 8'h33;
    cycle_start(); reset = 1'b1; wr_req = 1'b0; mid();
    chk("rack_ack_in_reset", 32'(wr_ack), 32'd0);
    cycle_start(); reset = 1'b0; wr_req = 1'b1; wr_addr = 12'd8; wr_data = 8'h44; mid();
    chk("rack_ack_after", 32'(wr_ack), 32'd0);
    chk("rack_new_we", 32'(ram_we), 32'd1);
    chk("rack_new_addr", 32'(ram_addr), 32'd8);
    exp_mem[8] = 8'h44;
    cycle_start(); mid();
    chk("rack_new_ack", 32'(wr_ack), 32'd1);
    cycle_start(); wr_req = 1'b0; mid();
    chk("total_we_count", 32'(we_count), 32'd5);
    chk("total_ack_count", 32'(ack_count), 32'd4);

    // Display address table; fetched data checked through the scoreboard.
    for (int i = 0; i < 12; i++) begin
      cycle_start();
      video_on = vecs[i].vo; p_tick = vecs[i].pt;
      pix_x = vecs[i].px; pix_y = vecs[i].py;
      if (vecs[i].fetch) exp_q.push_back(exp_mem[vecs[i].addr]);
      mid();
      chk("vec_addr", 32'(ram_addr), 32'(vecs[i].addr));
      chk("vec_we", 32'(ram_we), 32'd0);
    end
    cycle_start(); video_on = 1'b0; p_tick = 1'b0; mid();
    cycle_start(); mid();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
